// File: rtl/axi_lite_fifo_master.sv
// AXI-Lite master for the FIFO slave: local pushes become single-beat writes and
// local read requests become single-beat reads, with one transaction in flight.
module axi_lite_fifo_master #(
    parameter logic [63:0] DEVICE_ADDR = 64'h0000_0000_0000_00aa,
    parameter int          DATA_WIDTH  = 8,
    parameter int          TIMEOUT     = 256,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  rd_req,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [63:0]           AWADDR,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [31:0]           WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [63:0]           ARADDR,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [31:0]           RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic                  busy,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [2:0]            dbg_state_o
);

    // Handshakes: a transfer happens on any cycle where valid && ready are both high;
    // a valid, once raised, holds with stable payload until that transfer.

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4
    } state_e;

    localparam int              NBYTES   = (DATA_WIDTH + 7) / 8;
    localparam logic [3:0]      STRB     = (NBYTES >= 4) ? 4'hF : 4'((1 << NBYTES) - 1);
    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [1:0]      ERR_WR   = 2'b01;
    localparam logic [1:0]      ERR_RD   = 2'b10;
    localparam logic [1:0]      ERR_TMO  = 2'b11;

    state_e                 state_q, state_d;
    logic                   last_wr_q, last_wr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic wr_elig, rd_elig, grant_wr, grant_rd, tmo_hit, done;
    logic unused_rdata;

    assign unused_rdata = ^RDATA;

    assign wr_elig  = tx_valid;
    assign rd_elig  = rd_req && !rd_valid_q;
    // On a tie the side that did not win last time goes next.
    assign grant_wr = (state_q == IDLE) && wr_elig && (!rd_elig || !last_wr_q);
    assign grant_rd = (state_q == IDLE) && rd_elig && (!wr_elig || last_wr_q);
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        tmo_d       = tmo_q + 1'b1;
        done        = 1'b0;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (grant_wr) begin
                    wdata_d   = 32'(tx_data);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    last_wr_d = 1'b1;
                    state_d   = WR_ADDR_DATA;
                end else if (grant_rd) begin
                    arvalid_d = 1'b1;
                    last_wr_d = 1'b0;
                    state_d   = RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    done     = 1'b1;
                    bready_d = 1'b0;
                    state_d  = IDLE;
                    wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 1'b1;
                    if (BRESP != 2'b00) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_WR;
                    end
                end
            end
            RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    done       = 1'b1;
                    rready_d   = 1'b0;
                    rd_data_d  = RDATA[DATA_WIDTH-1:0];
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                    rd_cnt_d   = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 1'b1;
                    if (RRESP != 2'b00) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled transaction is dropped silently on the bus and reported locally.
        if (state_q != IDLE && !done && tmo_hit) begin
            state_d     = IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_wr_q   <= 1'b0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign tx_ready    = rst_n && grant_wr;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign AWADDR      = DEVICE_ADDR;
    assign AWPROT      = 3'b000;
    assign AWVALID     = awvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = STRB;
    assign WVALID      = wvalid_q;
    assign BREADY      = bready_q;
    assign ARADDR      = DEVICE_ADDR;
    assign ARPROT      = 3'b000;
    assign ARVALID     = arvalid_q;
    assign RREADY      = rready_q;
    assign busy        = (state_q != IDLE);
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_lite_fifo_master.sv
// Bench for axi_lite_fifo_master: directed and randomized transactions checked
// cycle by cycle against a transaction-level model of counters and error status.
module tb_axi_lite_fifo_master;

    localparam int TMO     = 8;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rd_req, rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic [63:0] AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        busy, err_pulse;
    logic [1:0]  err_code;
    logic [15:0] wr_cnt, rd_cnt;
    logic [2:0]  dbg_state;

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_wr   = 0;
    int         exp_rd   = 0;
    logic [1:0] exp_err  = 2'b00;

    axi_lite_fifo_master #(
        .DEVICE_ADDR (64'h0000_0000_0000_00aa),
        .DATA_WIDTH  (8),
        .TIMEOUT     (TMO),
        .CNT_WIDTH   (16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .busy(busy), .err_pulse(err_pulse), .err_code(err_code),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [1:0] resp);
        if (exp_wr != CNT_MAX) exp_wr++;
        if (resp != 2'b00) exp_err = 2'b01;
    endfunction

    function automatic void model_read(input logic [1:0] resp);
        if (exp_rd != CNT_MAX) exp_rd++;
        if (resp != 2'b00) exp_err = 2'b10;
    endfunction

    function automatic void model_reset();
        exp_wr  = 0;
        exp_rd  = 0;
        exp_err = 2'b00;
    endfunction

    task automatic set_idle();
        tx_valid = 1'b0; tx_data = 8'h00; rd_req = 1'b0; rd_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("awaddr", AWADDR, 64'haa);
        chk("araddr", ARADDR, 64'haa);
        chk("awprot", AWPROT, 0);
        chk("arprot", ARPROT, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_write(input logic [7:0] d, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] bresp);
        bit aw_done, w_done;
        aw_done = 1'b0;
        w_done  = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d;
        #1;
        chk("wr_tx_ready", tx_ready, 1);
        chk("wr_idle_busy", busy, 0);
        chk("wr_pulse_clear", err_pulse, 0);
        for (int k = 0; !(aw_done && w_done); k++) begin
            @(negedge clk);
            tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom);
            rd_req   = 1'($urandom_range(0, 1));
            AWREADY  = (k == aw_dly); WREADY = (k == w_dly);
            #1;
            chk("wr_awvalid", AWVALID, !aw_done);
            chk("wr_wvalid", WVALID, !w_done);
            chk("wr_wdata", WDATA, {24'h0, d});
            chk("wr_wstrb", WSTRB, 4'b0001);
            chk("wr_bready_early", BREADY, 0);
            chk("wr_busy", busy, 1);
            chk("wr_tx_ready_busy", tx_ready, 0);
            if (k == aw_dly) aw_done = 1'b1;
            if (k == w_dly)  w_done  = 1'b1;
        end
        for (int k = 0; k <= b_dly; k++) begin
            @(negedge clk);
            AWREADY  = 1'b0; WREADY = 1'b0;
            tx_valid = 1'($urandom_range(0, 1)); rd_req = 1'($urandom_range(0, 1));
            BVALID   = (k == b_dly);
            BRESP    = (k == b_dly) ? bresp : 2'($urandom);
            #1;
            chk("wr_bready", BREADY, 1);
            chk("wr_awvalid_resp", AWVALID, 0);
            chk("wr_wvalid_resp", WVALID, 0);
            chk("wr_busy_resp", busy, 1);
        end
        @(negedge clk);
        BVALID = 1'b0; BRESP = 2'b00; tx_valid = 1'b0; rd_req = 1'b0;
        model_write(bresp);
        #1;
        chk("wr_bready_drop", BREADY, 0);
        chk("wr_done_busy", busy, 0);
        chk("wr_cnt", wr_cnt, exp_wr);
        chk("wr_err_code", err_code, exp_err);
        chk("wr_err_pulse", err_pulse, bresp != 2'b00);
    endtask

    task automatic do_write_timeout(input logic [7:0] d, input int w_dly);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d;
        #1;
        chk("wto_tx_ready", tx_ready, 1);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            tx_valid = 1'($urandom_range(0, 1)); rd_req = 1'($urandom_range(0, 1));
            AWREADY  = 1'b0; WREADY = (k == w_dly);
            #1;
            chk("wto_awvalid", AWVALID, 1);
            chk("wto_wvalid", WVALID, k <= w_dly);
            chk("wto_busy", busy, 1);
            chk("wto_pulse_early", err_pulse, 0);
        end
        @(negedge clk);
        tx_valid = 1'b0; rd_req = 1'b0; WREADY = 1'b0;
        exp_err = 2'b11;
        #1;
        chk("wto_idle", busy, 0);
        chk("wto_awvalid_drop", AWVALID, 0);
        chk("wto_wvalid_drop", WVALID, 0);
        chk("wto_bready", BREADY, 0);
        chk("wto_err_pulse", err_pulse, 1);
        chk("wto_err_code", err_code, exp_err);
        chk("wto_wr_cnt", wr_cnt, exp_wr);
        @(negedge clk);
        BVALID = 1'b1; BRESP = 2'b00;
        #1;
        chk("wto_late_bready", BREADY, 0);
        chk("wto_pulse_once", err_pulse, 0);
        @(negedge clk);
        BVALID = 1'b0;
        #1;
        chk("wto_late_wr_cnt", wr_cnt, exp_wr);
        chk("wto_late_err_code", err_code, exp_err);
    endtask

    task automatic do_read(input logic [31:0] rdata, input int ar_dly, input int r_dly,
                           input logic [1:0] rresp, input int hold);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_valid", rd_valid, 0);
        chk("rd_pulse_clear", err_pulse, 0);
        for (int k = 0; k <= ar_dly; k++) begin
            @(negedge clk);
            rd_req   = 1'($urandom_range(0, 1)); tx_valid = 1'($urandom_range(0, 1));
            ARREADY  = (k == ar_dly);
            #1;
            chk("rd_arvalid", ARVALID, 1);
            chk("rd_rready_early", RREADY, 0);
            chk("rd_awvalid", AWVALID, 0);
            chk("rd_busy", busy, 1);
            chk("rd_tx_ready_busy", tx_ready, 0);
        end
        for (int k = 0; k <= r_dly; k++) begin
            @(negedge clk);
            ARREADY = 1'b0;
            RVALID  = (k == r_dly);
            RDATA   = (k == r_dly) ? rdata : $urandom;
            RRESP   = (k == r_dly) ? rresp : 2'($urandom);
            #1;
            chk("rd_rready", RREADY, 1);
            chk("rd_arvalid_drop", ARVALID, 0);
            chk("rd_valid_early", rd_valid, 0);
        end
        model_read(rresp);
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            RVALID = 1'b0; RRESP = 2'b00; RDATA = $urandom;
            tx_valid = 1'b0; rd_req = 1'b1; rd_ready = (k == hold);
            #1;
            chk("rd_valid_hold", rd_valid, 1);
            chk("rd_data", rd_data, rdata[7:0]);
            chk("rd_no_arvalid", ARVALID, 0);
            chk("rd_rready_drop", RREADY, 0);
            chk("rd_hold_busy", busy, 0);
            chk("rd_cnt", rd_cnt, exp_rd);
            chk("rd_err_code", err_code, exp_err);
            chk("rd_err_pulse", err_pulse, (k == 0) && (rresp != 2'b00));
        end
        @(negedge clk);
        rd_ready = 1'b0; rd_req = 1'b0;
        #1;
        chk("rd_valid_clear", rd_valid, 0);
        chk("rd_after_busy", busy, 0);
    endtask

    task automatic do_read_timeout(input int ar_dly);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("rto_idle_busy", busy, 0);
        for (int k = 0; k <= ar_dly; k++) begin
            @(negedge clk);
            rd_req  = 1'b0;
            ARREADY = (k == ar_dly);
            #1;
            chk("rto_arvalid", ARVALID, 1);
        end
        for (int k = 0; k < TMO - (ar_dly + 1); k++) begin
            @(negedge clk);
            ARREADY = 1'b0; RVALID = 1'b0;
            #1;
            chk("rto_rready", RREADY, 1);
            chk("rto_pulse_early", err_pulse, 0);
        end
        @(negedge clk);
        exp_err = 2'b11;
        #1;
        chk("rto_idle", busy, 0);
        chk("rto_rready_drop", RREADY, 0);
        chk("rto_arvalid_drop", ARVALID, 0);
        chk("rto_err_pulse", err_pulse, 1);
        chk("rto_err_code", err_code, exp_err);
        chk("rto_rd_valid", rd_valid, 0);
        chk("rto_rd_cnt", rd_cnt, exp_rd);
        @(negedge clk);
        RVALID = 1'b1; RDATA = $urandom; RRESP = 2'b00;
        #1;
        chk("rto_late_rready", RREADY, 0);
        chk("rto_pulse_once", err_pulse, 0);
        @(negedge clk);
        RVALID = 1'b0;
        #1;
        chk("rto_late_rd_valid", rd_valid, 0);
        chk("rto_late_rd_cnt", rd_cnt, exp_rd);
    endtask

    initial begin
        byte grants[$];
        byte exp_g[$];
        byte last_g;
        int  cyc;
        int  op;

        rst_n = 1'b0;
        set_idle();

        // reset state, then a write that stalls on AWREADY and must time out
        do_reset();
        do_write_timeout(8'h11, 99);

        // single clean write and a split AW/W handshake
        do_write(8'h5A, 0, 0, 0, 2'b00);
        do_write(8'hA7, 1, 4, 0, 2'b00);

        // read held under backpressure, then an erroring read and a read timeout
        do_read(32'h0000_00C3, 0, 0, 2'b00, 4);
        do_read(32'h1234_5699, 1, 2, 2'b10, 0);
        do_read_timeout(2);

        // both requesters held high: grants alternate starting with the write
        do_reset();
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hDEAD_BE77; RRESP = 2'b00;
        rd_ready = 1'b1;
        last_g = "R";
        for (int i = 0; i < 4; i++) begin
            last_g = (last_g == "R") ? "W" : "R";
            exp_g.push_back(last_g);
        end
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            @(negedge clk);
            tx_valid = 1'b1; rd_req = 1'b1; tx_data = 8'($urandom);
            #1;
            if (tx_ready) grants.push_back("W");
            if (ARVALID)  grants.push_back("R");
            cyc++;
        end
        repeat (3) begin
            @(negedge clk);
            tx_valid = 1'b0; rd_req = 1'b0;
        end
        #1;
        chk("arb_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk("arb_order", grants[i], exp_g[i]);
            if (exp_g[i] == "W") model_write(2'b00);
            else                 model_read(2'b00);
        end
        chk("arb_wr_cnt", wr_cnt, exp_wr);
        chk("arb_rd_cnt", rd_cnt, exp_rd);
        chk("arb_rd_data", rd_data, 8'h77);
        chk("arb_rd_valid", rd_valid, 0);
        set_idle();

        // randomized mix of transactions against the model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                do_write(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2),
                         ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end else if (op <= 7) begin
                do_read($urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                        $urandom_range(0, 3));
            end else if (op == 8) begin
                do_write_timeout(8'($urandom), $urandom_range(0, 10));
            end else begin
                do_read_timeout($urandom_range(0, 5));
            end
        end

        // write error, then reset while a read waits for data
        do_write(8'h3C, 0, 0, 0, 2'b10);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0; ARREADY = 1'b1;
        #1;
        chk("rr_arvalid", ARVALID, 1);
        @(negedge clk);
        ARREADY = 1'b0;
        #1;
        chk("rr_rready", RREADY, 1);
        chk("rr_busy", busy, 1);
        rst_n = 1'b0; RVALID = 1'b1; RDATA = 32'h0000_0055;
        @(negedge clk);
        #1;
        model_reset();
        chk("rr_rready_rst", RREADY, 0);
        chk("rr_busy_rst", busy, 0);
        chk("rr_wr_cnt", wr_cnt, exp_wr);
        chk("rr_rd_cnt", rd_cnt, exp_rd);
        chk("rr_err_code", err_code, exp_err);
        chk("rr_rd_valid", rd_valid, 0);
        chk("rr_err_pulse", err_pulse, 0);
        RVALID = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_after_rd_valid", rd_valid, 0);
        chk("rr_after_rd_cnt", rd_cnt, exp_rd);
        chk("rr_after_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
